// File: rtl/if_prefetch_if.sv
// if_prefetch_if: ROM fetch, redirect and decode handshake bundle of the prefetcher.
interface if_prefetch_if #(
   parameter int ADDR_W = 32,
   parameter int INST_W = 32,
   parameter int DEPTH  = 4
);
   localparam int LW = $clog2(DEPTH) + 1;
   logic              rom_ce_o;
   logic [ADDR_W-1:0] rom_addr_o;
   logic              rom_rdy_i;
   logic              rom_rvalid_i;
   logic [INST_W-1:0] rom_data_i;
   logic              redirect_i;
   logic [ADDR_W-1:0] redirect_pc_i;
   logic              id_valid_o;
   logic [ADDR_W-1:0] id_pc_o;
   logic [INST_W-1:0] id_inst_o;
   logic              id_ready_i;
   logic [LW-1:0]     fifo_level_o;
   modport master (
      output rom_ce_o, rom_addr_o, id_valid_o, id_pc_o, id_inst_o, fifo_level_o,
      input  rom_rdy_i, rom_rvalid_i, rom_data_i, redirect_i, redirect_pc_i, id_ready_i
   );
   modport slave (
      input  rom_ce_o, rom_addr_o, id_valid_o, id_pc_o, id_inst_o, fifo_level_o,
      output rom_rdy_i, rom_rvalid_i, rom_data_i, redirect_i, redirect_pc_i, id_ready_i
   );
endinterface

// File: rtl/if_prefetch.sv
// if_prefetch: credit-limited in-order fetch into a PC/instruction FIFO toward decode,
// with redirect flushing the FIFO and discarding responses still in flight.
module if_prefetch #(
   parameter int                ADDR_W   = 32,
   parameter int                INST_W   = 32,
   parameter int                DEPTH    = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input logic           clk,
   input logic           rst,
   if_prefetch_if.master bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int LW = PW + 1;
   localparam logic [LW:0]       CAP  = DEPTH;
   localparam logic [ADDR_W-1:0] STEP = ADDR_W'(INST_W / 8);
   logic [ADDR_W-1:0]        fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d;
   logic [LW-1:0]            out_q, out_d, discard_q, discard_d, level_q, level_d;
   logic [PW-1:0]            wptr_q, wptr_d, rptr_q, rptr_d;
   logic [ADDR_W+INST_W-1:0] mem_q [DEPTH];
   logic [LW:0]              credit;
   logic                     accept, resp, push, pop;
   always_comb begin
      // buffered plus in-flight words may never exceed the FIFO size
      credit           = {1'b0, level_q} + {1'b0, out_q};
      bus.rom_ce_o     = rst && !bus.redirect_i && credit < CAP;
      bus.rom_addr_o   = fetch_pc_q;
      accept           = bus.rom_ce_o && bus.rom_rdy_i;
      resp             = bus.rom_rvalid_i && out_q != '0;
      push             = resp && discard_q == '0 && !bus.redirect_i;
      bus.id_valid_o   = level_q != '0 && !bus.redirect_i;
      pop              = bus.id_valid_o && bus.id_ready_i;
      {bus.id_pc_o, bus.id_inst_o} = level_q != '0 ? mem_q[rptr_q] : '0;
      bus.fifo_level_o = level_q;
      out_d      = out_q + LW'(accept) - LW'(resp);
      fetch_pc_d = bus.redirect_i ? bus.redirect_pc_i : accept ? fetch_pc_q + STEP : fetch_pc_q;
      resp_pc_d  = bus.redirect_i ? bus.redirect_pc_i : push ? resp_pc_q + STEP : resp_pc_q;
      // on redirect every word still owed by the ROM is stale
      discard_d  = bus.redirect_i ? out_d : discard_q - LW'(resp && discard_q != '0);
      level_d    = bus.redirect_i ? '0 : level_q + LW'(push) - LW'(pop);
      wptr_d     = bus.redirect_i ? '0 : wptr_q + PW'(push);
      rptr_d     = bus.redirect_i ? '0 : rptr_q + PW'(pop);
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fetch_pc_q <= RESET_PC;
         resp_pc_q  <= RESET_PC;
         out_q      <= '0;
         discard_q  <= '0;
         level_q    <= '0;
         wptr_q     <= '0;
         rptr_q     <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         resp_pc_q  <= resp_pc_d;
         out_q      <= out_d;
         discard_q  <= discard_d;
         level_q    <= level_d;
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
      end
   end
   always_ff @(posedge clk) begin
      if (push) mem_q[wptr_q] <= {resp_pc_q, bus.rom_data_i};
   end
endmodule

// File: tb/tb_if_prefetch.sv
// tb_if_prefetch: directed checks of fetch, backpressure, redirect, stall, wrap and reset
// against a variable-latency ROM model.
module tb_if_prefetch;
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;
   if_prefetch_if #(.ADDR_W(32), .INST_W(32), .DEPTH(4)) b1 ();
   if_prefetch_if #(.ADDR_W(32), .INST_W(32), .DEPTH(4)) b2 ();
   if_prefetch #(.ADDR_W(32), .INST_W(32), .DEPTH(4), .RESET_PC(32'h0))
      dut (.clk(clk), .rst(rst), .bus(b1.master));
   if_prefetch #(.ADDR_W(32), .INST_W(32), .DEPTH(4), .RESET_PC(32'hFFFF_FFF8))
      dut2 (.clk(clk), .rst(rst), .bus(b2.master));
   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int lat = 1;
   logic [31:0] qa[$];
   int          qd[$];

   function automatic logic [31:0] f(input logic [31:0] a);
      return {a[15:0], ~a[15:0]};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic head(input string tag, input logic [31:0] pc);
      chk({tag, ".valid"}, b1.id_valid_o, 1);
      chk({tag, ".pc"}, b1.id_pc_o, pc);
      chk({tag, ".inst"}, b1.id_inst_o, f(pc));
   endtask

   task automatic head2(input string tag, input logic [31:0] pc);
      chk({tag, ".valid"}, b2.id_valid_o, 1);
      chk({tag, ".pc"}, b2.id_pc_o, pc);
      chk({tag, ".inst"}, b2.id_inst_o, f(pc));
   endtask

   // one clock: record accepted requests, then present the ROM responses due this cycle
   task automatic tick();
      logic        acc, acc2;
      logic [31:0] a, a2;
      acc  = b1.rom_ce_o & b1.rom_rdy_i;
      acc2 = b2.rom_ce_o & b2.rom_rdy_i;
      a    = b1.rom_addr_o;
      a2   = b2.rom_addr_o;
      @(posedge clk);
      cyc++;
      if (acc) begin
         qa.push_back(a);
         qd.push_back(cyc - 1 + lat);
      end
      #1;
      if (qa.size() > 0 && qd[0] <= cyc) begin
         b1.rom_rvalid_i = 1'b1;
         b1.rom_data_i   = f(qa.pop_front());
         void'(qd.pop_front());
      end else begin
         b1.rom_rvalid_i = 1'b0;
         b1.rom_data_i   = '0;
      end
      b2.rom_rvalid_i = acc2;
      b2.rom_data_i   = f(a2);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      b1.rom_rdy_i = 1'b1;
      b1.id_ready_i = 1'b1;
      b1.redirect_i = 1'b0;
      lat = 1;
      repeat (5) tick();
      rst = 1'b1;
      #1;
   endtask

   initial begin
      b1.rom_rdy_i = 1'b1; b1.rom_rvalid_i = 1'b0; b1.rom_data_i = '0;
      b1.redirect_i = 1'b0; b1.redirect_pc_i = '0; b1.id_ready_i = 1'b1;
      b2.rom_rdy_i = 1'b1; b2.rom_rvalid_i = 1'b0; b2.rom_data_i = '0;
      b2.redirect_i = 1'b0; b2.redirect_pc_i = '0; b2.id_ready_i = 1'b1;
      #2;
      tick(); tick();
      chk("rst.ce", b1.rom_ce_o, 0);
      chk("rst.valid", b1.id_valid_o, 0);
      chk("rst.pc", b1.id_pc_o, 0);
      chk("rst.inst", b1.id_inst_o, 0);
      chk("rst.level", b1.fifo_level_o, 0);
      chk("rst.ce2", b2.rom_ce_o, 0);
      // streaming fetch, plus wrap-around on the second instance
      rst = 1'b1; #1;
      chk("t1.ce", b1.rom_ce_o, 1);
      chk("t1.a0", b1.rom_addr_o, 32'h0);
      chk("t5.a0", b2.rom_addr_o, 32'hFFFF_FFF8);
      tick();
      chk("t1.a4", b1.rom_addr_o, 32'h4);
      chk("t1.v0", b1.id_valid_o, 0);
      chk("t5.a1", b2.rom_addr_o, 32'hFFFF_FFFC);
      tick();
      head("t1.h0", 32'h0);
      chk("t1.a8", b1.rom_addr_o, 32'h8);
      head2("t5.h0", 32'hFFFF_FFF8);
      chk("t5.a2", b2.rom_addr_o, 32'h0);
      tick();
      head("t1.h4", 32'h4);
      head2("t5.h1", 32'hFFFF_FFFC);
      tick();
      head("t1.h8", 32'h8);
      head2("t5.h2", 32'h0);
      // decode backpressure fills the FIFO and stops requests
      do_reset();
      b1.id_ready_i = 1'b0; #1;
      repeat (4) tick();
      chk("t2.ce3", b1.rom_ce_o, 0);
      chk("t2.lvl3", b1.fifo_level_o, 3);
      tick();
      chk("t2.ce", b1.rom_ce_o, 0);
      chk("t2.lvl", b1.fifo_level_o, 4);
      chk("t2.addr", b1.rom_addr_o, 32'h10);
      tick();
      chk("t2.ce_hold", b1.rom_ce_o, 0);
      chk("t2.lvl_hold", b1.fifo_level_o, 4);
      b1.id_ready_i = 1'b1; #1;
      head("t2.h0", 32'h0);
      tick();
      head("t2.h4", 32'h4);
      chk("t2.ce_res", b1.rom_ce_o, 1);
      chk("t2.a10", b1.rom_addr_o, 32'h10);
      tick();
      head("t2.h8", 32'h8);
      tick();
      head("t2.hc", 32'hC);
      chk("t2.lvl2", b1.fifo_level_o, 2);
      tick();
      head("t2.h10", 32'h10);
      // redirect with three requests in flight on a 3-cycle ROM
      do_reset();
      lat = 3;
      repeat (3) tick();
      b1.redirect_i = 1'b1; b1.redirect_pc_i = 32'h100; #1;
      chk("t3.ce_rd", b1.rom_ce_o, 0);
      chk("t3.v_rd", b1.id_valid_o, 0);
      tick();
      b1.redirect_i = 1'b0; #1;
      chk("t3.a100", b1.rom_addr_o, 32'h100);
      chk("t3.v4", b1.id_valid_o, 0);
      tick();
      chk("t3.v5", b1.id_valid_o, 0);
      tick();
      chk("t3.v6", b1.id_valid_o, 0);
      tick();
      chk("t3.v7", b1.id_valid_o, 0);
      chk("t3.lvl7", b1.fifo_level_o, 0);
      tick();
      head("t3.h100", 32'h100);
      tick();
      head("t3.h104", 32'h104);
      // ROM stalls alternate with accepts
      do_reset();
      b1.rom_rdy_i = 1'b0; #1;
      chk("t4.ce", b1.rom_ce_o, 1);
      chk("t4.a0", b1.rom_addr_o, 32'h0);
      tick();
      chk("t4.a0_hold", b1.rom_addr_o, 32'h0);
      b1.rom_rdy_i = 1'b1; #1;
      tick();
      b1.rom_rdy_i = 1'b0; #1;
      chk("t4.a4", b1.rom_addr_o, 32'h4);
      chk("t4.v2", b1.id_valid_o, 0);
      tick();
      b1.rom_rdy_i = 1'b1; #1;
      head("t4.h0", 32'h0);
      chk("t4.a4_hold", b1.rom_addr_o, 32'h4);
      tick();
      b1.rom_rdy_i = 1'b0; #1;
      chk("t4.a8", b1.rom_addr_o, 32'h8);
      chk("t4.v4", b1.id_valid_o, 0);
      tick();
      b1.rom_rdy_i = 1'b1; #1;
      head("t4.h4", 32'h4);
      chk("t4.a8_hold", b1.rom_addr_o, 32'h8);
      tick();
      b1.rom_rdy_i = 1'b0; #1;
      chk("t4.ac", b1.rom_addr_o, 32'hC);
      tick();
      head("t4.h8", 32'h8);
      // reset with two requests in flight; late responses must be ignored
      do_reset();
      lat = 3;
      tick(); tick();
      rst = 1'b0; #1;
      chk("t6.ce", b1.rom_ce_o, 0);
      chk("t6.valid", b1.id_valid_o, 0);
      chk("t6.pc", b1.id_pc_o, 0);
      chk("t6.inst", b1.id_inst_o, 0);
      chk("t6.level", b1.fifo_level_o, 0);
      b1.rom_rdy_i = 1'b0;
      tick();
      rst = 1'b1; #1;
      chk("t6.ce_up", b1.rom_ce_o, 1);
      chk("t6.a0", b1.rom_addr_o, 32'h0);
      tick();
      chk("t6.lvl4", b1.fifo_level_o, 0);
      tick();
      chk("t6.lvl5", b1.fifo_level_o, 0);
      chk("t6.v5", b1.id_valid_o, 0);
      b1.rom_rdy_i = 1'b1; #1;
      repeat (4) tick();
      head("t6.h0", 32'h0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
